// File: rtl/int_src_ctrl_if.sv
// Single-cycle register port between the SoC interconnect and the interrupt source controller.
interface int_src_ctrl_if;
  logic        reg_req;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_resp;

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata,
    input  reg_rdata, reg_resp
  );

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata,
    output reg_rdata, reg_resp
  );
endinterface

// File: rtl/int_src_ctrl.sv
// Interrupt source controller: synchronizes 8 external IRQ lines, applies polarity/mode/enable,
// holds pending state, and provides a software IPI mailbox feeding the CSR interrupt inputs.
module int_src_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int IPI_WIDTH   = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [7:0]   irq_raw,
  int_src_ctrl_if.slave bus,
  output logic [7:0]   hw_int_out,
  output logic         ipi_int_out
);

  localparam logic [3:0] A_EN      = 4'd0;
  localparam logic [3:0] A_MODE    = 4'd1;
  localparam logic [3:0] A_POL     = 4'd2;
  localparam logic [3:0] A_PEND    = 4'd3;
  localparam logic [3:0] A_LEVEL   = 4'd4;
  localparam logic [3:0] A_IPI_ST  = 4'd5;
  localparam logic [3:0] A_IPI_SET = 4'd6;
  localparam logic [3:0] A_IPI_CLR = 4'd7;
  localparam logic [3:0] A_IPI_EN  = 4'd8;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]           en_q, en_d;
  logic [7:0]           mode_q, mode_d;
  logic [7:0]           pol_q, pol_d;
  logic [7:0]           pend_q, pend_d;
  logic [7:0]           prev_q, prev_d;
  logic [7:0]           hw_q;
  logic [IPI_WIDTH-1:0] ipi_st_q, ipi_st_d;
  logic [IPI_WIDTH-1:0] ipi_en_q, ipi_en_d;
  logic                 ipi_q;
  logic [31:0]          rdata_q, rdata_d;
  logic                 resp_q;

  logic [7:0] s_sync;
  logic [7:0] lvl;
  logic [7:0] rise;
  logic [7:0] w1c;
  logic [7:0] mode_to_edge;
  logic       wr;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign lvl    = s_sync ^ pol_q;
  assign rise   = lvl & ~prev_q;
  assign wr     = bus.reg_req & bus.reg_we;

  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    pol_d    = pol_q;
    ipi_st_d = ipi_st_q;
    ipi_en_d = ipi_en_q;
    w1c      = '0;
    if (wr) begin
      case (bus.reg_addr)
        A_EN:      en_d     = bus.reg_wdata[7:0];
        A_MODE:    mode_d   = bus.reg_wdata[7:0];
        A_POL:     pol_d    = bus.reg_wdata[7:0];
        A_PEND:    w1c      = bus.reg_wdata[7:0] & mode_q;
        A_IPI_SET: ipi_st_d = ipi_st_q | bus.reg_wdata[IPI_WIDTH-1:0];
        A_IPI_CLR: ipi_st_d = ipi_st_q & ~bus.reg_wdata[IPI_WIDTH-1:0];
        A_IPI_EN:  ipi_en_d = bus.reg_wdata[IPI_WIDTH-1:0];
        default: ;
      endcase
    end

    // Edge lines: a new edge beats a coincident W1C. Level lines track lvl directly.
    mode_to_edge = mode_d & ~mode_q;
    pend_d = ((mode_q & (rise | (pend_q & ~w1c))) | (~mode_q & lvl)) & ~mode_to_edge;

    // Reload edge history with the post-write polarity so reconfiguration never fakes an edge.
    prev_d = s_sync ^ pol_d;

    rdata_d = '0;
    if (bus.reg_req && !bus.reg_we) begin
      case (bus.reg_addr)
        A_EN:     rdata_d = {24'd0, en_q};
        A_MODE:   rdata_d = {24'd0, mode_q};
        A_POL:    rdata_d = {24'd0, pol_q};
        A_PEND:   rdata_d = {24'd0, pend_q};
        A_LEVEL:  rdata_d = {24'd0, lvl};
        A_IPI_ST: rdata_d = 32'(ipi_st_q);
        A_IPI_EN: rdata_d = 32'(ipi_en_q);
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q   <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      pol_q    <= '0;
      pend_q   <= '0;
      prev_q   <= '0;
      hw_q     <= '0;
      ipi_st_q <= '0;
      ipi_en_q <= '0;
      ipi_q    <= 1'b0;
      rdata_q  <= '0;
      resp_q   <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
      end else begin
        sync_q <= irq_raw;
      end
      en_q     <= en_d;
      mode_q   <= mode_d;
      pol_q    <= pol_d;
      pend_q   <= pend_d;
      prev_q   <= prev_d;
      hw_q     <= pend_q & en_q;
      ipi_st_q <= ipi_st_d;
      ipi_en_q <= ipi_en_d;
      ipi_q    <= |(ipi_st_q & ipi_en_q);
      rdata_q  <= rdata_d;
      resp_q   <= bus.reg_req;
    end
  end

  assign hw_int_out    = hw_q;
  assign ipi_int_out   = ipi_q;
  assign bus.reg_rdata = rdata_q;
  assign bus.reg_resp  = resp_q;

endmodule

// File: tb/tb_int_src_ctrl.sv
// Randomized and directed checks of int_src_ctrl against a behavioural register-level model.
module tb_int_src_ctrl;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] irq_raw = '0;
  logic [7:0] hw_int_out;
  logic       ipi_int_out;

  int_src_ctrl_if bus();

  int_src_ctrl #(.SYNC_STAGES(SYNC), .IPI_WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .irq_raw    (irq_raw),
    .bus        (bus),
    .hw_int_out (hw_int_out),
    .ipi_int_out(ipi_int_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0]  m_en, m_mode, m_pol, m_pend, m_prev, m_hw;
  logic [31:0] m_ist, m_iel, m_rdata;
  logic        m_ipi, m_resp, m_rd_valid;
  logic [7:0]  m_pipe[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_prev = '0; m_hw = '0;
    m_ist = '0; m_iel = '0; m_rdata = '0; m_ipi = 1'b0; m_resp = 1'b0; m_rd_valid = 1'b0;
    m_pipe.delete();
    for (int k = 0; k < SYNC; k++) m_pipe.push_back(8'h00);
  endtask

  // One clock edge of the register-level behaviour, using pre-edge state throughout.
  task automatic model_edge(input logic req, input logic we, input logic [3:0] addr,
                            input logic [31:0] wd, input logic [7:0] raw);
    logic [7:0]  synced, lvl, n_en, n_mode, n_pol, n_pend;
    logic [31:0] rd, n_ist, n_iel;
    synced = m_pipe[0];
    lvl    = synced ^ m_pol;
    rd = 0;
    if (req && !we) begin
      case (addr)
        4'd0: rd = {24'd0, m_en};
        4'd1: rd = {24'd0, m_mode};
        4'd2: rd = {24'd0, m_pol};
        4'd3: rd = {24'd0, m_pend};
        4'd4: rd = {24'd0, lvl};
        4'd5: rd = m_ist;
        4'd8: rd = m_iel;
        default: rd = 0;
      endcase
    end
    n_en = m_en; n_mode = m_mode; n_pol = m_pol; n_ist = m_ist; n_iel = m_iel;
    if (req && we) begin
      if (addr == 4'd0) n_en   = wd[7:0];
      if (addr == 4'd1) n_mode = wd[7:0];
      if (addr == 4'd2) n_pol  = wd[7:0];
      if (addr == 4'd6) n_ist  = m_ist | wd;
      if (addr == 4'd7) n_ist  = m_ist & ~wd;
      if (addr == 4'd8) n_iel  = wd;
    end
    for (int i = 0; i < 8; i++) begin
      if (!m_mode[i]) n_pend[i] = lvl[i];
      else if (lvl[i] && !m_prev[i]) n_pend[i] = 1'b1;
      else if (req && we && addr == 4'd3 && wd[i]) n_pend[i] = 1'b0;
      else n_pend[i] = m_pend[i];
      if (!m_mode[i] && n_mode[i]) n_pend[i] = 1'b0;
    end
    m_hw   = m_pend & m_en;
    m_ipi  = |(m_ist & m_iel);
    m_prev = synced ^ n_pol;
    m_en = n_en; m_mode = n_mode; m_pol = n_pol; m_pend = n_pend; m_ist = n_ist; m_iel = n_iel;
    m_rdata = rd; m_resp = req; m_rd_valid = req && !we;
    m_pipe.push_back(raw);
    void'(m_pipe.pop_front());
  endtask

  task automatic step(input logic req, input logic we, input logic [3:0] addr,
                      input logic [31:0] wd, input logic [7:0] raw);
    bus.reg_req = req; bus.reg_we = we; bus.reg_addr = addr; bus.reg_wdata = wd;
    irq_raw = raw;
    @(posedge clk);
    model_edge(req, we, addr, wd, raw);
    #1;
    chk_eq("hw_int_out", {24'd0, hw_int_out}, {24'd0, m_hw});
    chk_eq("ipi_int_out", {31'd0, ipi_int_out}, {31'd0, m_ipi});
    chk_eq("reg_resp", {31'd0, bus.reg_resp}, {31'd0, m_resp});
    if (m_rd_valid || !m_resp) chk_eq("reg_rdata", bus.reg_rdata, m_rdata);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d, irq_raw);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b1, 1'b0, a, 32'd0, irq_raw);
  endtask

  task automatic idle(input int n, input logic [7:0] raw);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 32'd0, raw);
  endtask

  initial begin
    bus.reg_req = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset_hw", {24'd0, hw_int_out}, 32'd0);
    chk_eq("reset_resp", {31'd0, bus.reg_resp}, 32'd0);
    resetn = 1'b1;

    // Level line 0: assertion and deassertion latency
    wr(4'd0, 32'h01); wr(4'd1, 32'h00); wr(4'd2, 32'h00);
    idle(4, 8'h01);
    chk_eq("level_assert_edge4", {24'd0, hw_int_out}, 32'h01);
    rd(4'd3);
    chk_eq("level_pend_read", bus.reg_rdata, 32'h01);
    idle(4, 8'h00);
    chk_eq("level_deassert", {24'd0, hw_int_out}, 32'h00);

    // Edge line 2 with W1C, then W1C coincident with a new edge
    wr(4'd0, 32'h04); wr(4'd1, 32'h04);
    idle(1, 8'h04); idle(5, 8'h00);
    rd(4'd3);
    chk_eq("edge_pend_held", bus.reg_rdata, 32'h04);
    wr(4'd3, 32'h04); idle(2, 8'h00);
    chk_eq("edge_w1c_cleared", {24'd0, hw_int_out}, 32'h00);
    idle(1, 8'h04); idle(1, 8'h00);
    wr(4'd3, 32'h04);
    rd(4'd3);
    chk_eq("edge_set_beats_clr", bus.reg_rdata, 32'h04);
    wr(4'd3, 32'h04);

    // Active-low reconfiguration on edge line 5
    wr(4'd1, 32'h24); idle(3, 8'h00);
    wr(4'd2, 32'h20); idle(3, 8'h00);
    rd(4'd3);
    chk_eq("pol_no_spurious", bus.reg_rdata & 32'h20, 32'h00);
    idle(4, 8'h20);
    rd(4'd3);
    chk_eq("pol_rise_ignored", bus.reg_rdata & 32'h20, 32'h00);
    idle(4, 8'h00);
    rd(4'd3);
    chk_eq("pol_fall_latched", bus.reg_rdata & 32'h20, 32'h20);

    // Masked latch on edge line 7
    wr(4'd2, 32'h00); wr(4'd0, 32'h00); wr(4'd1, 32'h80); wr(4'd3, 32'hFF);
    idle(1, 8'h80); idle(4, 8'h00);
    chk_eq("masked_hw", {24'd0, hw_int_out}, 32'h00);
    rd(4'd3);
    chk_eq("masked_pend", bus.reg_rdata, 32'h80);
    wr(4'd0, 32'h80); idle(1, 8'h00);
    chk_eq("unmask_hw", {24'd0, hw_int_out}, 32'h80);

    // IPI mailbox
    wr(4'd8, 32'h1); wr(4'd6, 32'h3); idle(1, 8'h00);
    chk_eq("ipi_set_out", {31'd0, ipi_int_out}, 32'd1);
    rd(4'd5);
    chk_eq("ipi_status3", bus.reg_rdata, 32'h3);
    wr(4'd7, 32'h1); idle(1, 8'h00);
    chk_eq("ipi_clr_out", {31'd0, ipi_int_out}, 32'd0);
    rd(4'd6); rd(4'd12);
    chk_eq("unmapped_resp", {31'd0, bus.reg_resp}, 32'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0]  raw;
      logic [31:0] d;
      logic [3:0]  a;
      raw = irq_raw ^ (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      if (a == 4'd1 || a == 4'd2) d = ($urandom_range(0, 7) == 0) ? d : {24'd0, (a == 4'd1) ? m_mode : m_pol};
      case ($urandom_range(0, 3))
        0, 1: step(1'b0, 1'b0, a, d, raw);
        2:    step(1'b1, 1'b0, a, d, raw);
        default: step(1'b1, 1'b1, a, d, raw);
      endcase
    end

    // Async reset mid-cycle with everything asserted
    wr(4'd2, 32'h00); wr(4'd1, 32'h00); wr(4'd0, 32'hFF);
    idle(5, 8'hFF);
    chk_eq("pre_reset_hw", {24'd0, hw_int_out}, 32'hFF);
    irq_raw = 8'h00;
    #3 resetn = 1'b0;
    #1;
    chk_eq("async_hw", {24'd0, hw_int_out}, 32'h00);
    chk_eq("async_ipi", {31'd0, ipi_int_out}, 32'd0);
    chk_eq("async_rdata", bus.reg_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    for (int a = 0; a < 9; a++) rd(4'(a));
    idle(6, 8'h00);
    chk_eq("post_reset_quiet", {24'd0, hw_int_out}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/int_src_ctrl.md
Name: int_src_ctrl

Overview:
- Interrupt source controller that generates the hardware and inter-processor interrupt levels consumed by the CSR block's ESTAT.IS[9:2] and IS[12] inputs.
- Synchronizes 8 asynchronous external IRQ lines. Applies per-line polarity, edge/level mode and enable, and holds pending state.
- Implements a software IPI mailbox.
- Configured over a simple single-cycle register port from the SoC interconnect side.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per IRQ line (legal range 2..4).
- IPI_WIDTH, 32, width of the IPI status/enable mailbox.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset; assertion clears all state immediately
- irq_raw  in  8  asynchronous external interrupt lines
- reg_req  in  1  register access request, single-cycle pulse, accepted unconditionally
- reg_we  in  1  1 = write, 0 = read
- reg_addr  in  4  register word index
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, valid with reg_resp
- reg_resp  out  1  one-cycle response pulse, issued for both reads and writes
- hw_int_out  out  8  to CSR hw_int_in[7:0]
- ipi_int_out  out  1  to CSR ipi_int_in

Behaviour:
- Reset: all registers are 0, including synchronizers, edge history, POL/MODE/EN/PEND, IPI status/enable, reg_rdata, reg_resp, hw_int_out and ipi_int_out.
- Synchronizer: irq_raw[i] passes through SYNC_STAGES flops, giving s_sync[i].
  - Polarity: lvl[i] = s_sync[i] ^ POL[i], where POL = 1 means active-low.
- Edge history: prev[i] <= lvl[i] every cycle.
- Pending update, per line per cycle:
  - MODE[i] = 0 (level): PEND[i] <= lvl[i]. W1C writes have no effect on level lines.
  - MODE[i] = 1 (edge): PEND[i] is set on lvl & ~prev. It is cleared by a W1C write with reg_wdata[i] = 1. If set and clear occur in the same cycle, set wins.
- Output: hw_int_out <= PEND & EN (registered).
  - Latency with SYNC_STAGES = 2: irq_raw sampled high at edge 1 gives hw_int_out high after edge 4.
  - Deassertion in level mode follows with the same latency.
- IPI:
  - IPI_SET write: status <= status | wdata.
  - IPI_CLR write: status <= status & ~wdata.
  - ipi_int_out <= |(status & IPI_EN).
  - Same-cycle set and clear of the same bit is impossible, since there is one port with one access per cycle.
- Register map (reg_addr):
  - 0 EN (RW, 8b)
  - 1 MODE (RW, 8b)
  - 2 POL (RW, 8b)
  - 3 PEND (R; W1C for edge lines)
  - 4 LEVEL (R, lvl[7:0])
  - 5 IPI_STATUS (R)
  - 6 IPI_SET (W, reads 0)
  - 7 IPI_CLR (W, reads 0)
  - 8 IPI_EN (RW)
  - 9..15: unmapped; reads return 0, writes are ignored.
  - Upper unused bits read as 0.
- Register port:
  - A write takes effect at the edge where reg_req is sampled.
  - reg_resp pulses the next cycle.
  - reg_rdata is registered from pre-write state, is valid only while reg_resp = 1, and is 0 otherwise.
  - Back-to-back requests every cycle are supported.
- Configuration side effects:
  - Writing POL or MODE loads prev[i] with the new-polarity lvl[i] for every line whose bit changed. No spurious edge is detected from the reconfiguration.
  - A MODE change from level to edge clears PEND[i].
- Disabled lines: EN[i] = 0 only masks the output. PEND continues to latch edges, and enabling later exposes the held pending bit.
- Reset mid-operation: asynchronous clear. Outputs drop within the reset assertion without waiting for a clock edge.

Test Plan:
- Level line: reset, write EN = 0x01, MODE = 0, POL = 0; drive irq_raw[0] = 1 at edge 1 -> hw_int_out = 0x01 after edge 4; drop irq_raw[0] -> 0x00 four edges later; reading PEND returns 0x01 while asserted.
- Edge line with W1C: EN = 0x04, MODE = 0x04; 1-cycle pulse on irq_raw[2] -> PEND = 0x04 held after the pulse ends; write PEND = 0x04 -> hw_int_out = 0x00 two edges later; W1C coincident with a new edge -> PEND stays 0x04.
- Active-low plus reconfiguration: irq_raw[5] held 0, POL = 0x20 written while MODE[5] = 1 -> no PEND set; then raise irq_raw[5] and lower it again -> PEND[5] = 1 only on the falling raw edge.
- Masked latch: EN = 0, edge line 7 pulsed -> hw_int_out = 0, PEND = 0x80; write EN = 0x80 -> hw_int_out = 0x80 next edge.
- IPI: IPI_EN = 0x1; write IPI_SET = 0x3 -> STATUS = 0x3, ipi_int_out = 1; write IPI_CLR = 0x1 -> STATUS = 0x2, ipi_int_out = 0; read addr 6 and addr 12 -> 0 with reg_resp.
- Async reset: assert resetn = 0 between clock edges with hw_int_out = 0xFF -> outputs and all registers 0 immediately; release -> no interrupts until a new qualifying source event occurs.
